mem_fill_responder: RTL and testbench
=====================================

Name: mem_fill_responder

Overview:
Word-addressed main-memory model that answers cache fill and write requests over a valid/ready request channel and a valid/ready response channel.
- Read requests return one full block as a burst, critical word first, after a programmable latency.
- Write requests update one word and return a single acknowledge beat.
- Sits below the L2 of the two-level cache and replaces its hard-wired memory constant.

Parameters:
- ADDR_WIDTH, 11, word address width; memory holds 2**ADDR_WIDTH words.
- DATA_WIDTH, 11, word width.
- BLOCK_WORDS, 16, words per fill burst; power of two, at least 2.
- LATENCY, 4, idle cycles between read acceptance and the first beat; range 0..255.
- FILL_PATTERN, 11'h3F3, reset contents seed: mem[a] = FILL_PATTERN ^ a, with a truncated or zero-extended to DATA_WIDTH.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE.
- req_addr  in  ADDR_WIDTH  word address; critical word for reads.
- req_we  in  1  1 = write, 0 = block read.
- req_wdata  in  DATA_WIDTH  write data.
- resp_valid  out  1  response beat present.
- resp_ready  in  1  consumer accepts beat.
- resp_data  out  DATA_WIDTH  beat data; write ack echoes written data.
- resp_last  out  1  final beat of the response.
- resp_we  out  1  beat is a write acknowledge.

Behaviour:
- Reset (rst low, asynchronous):
  - State goes to IDLE; req_ready=0 while rst low, 1 on the first cycle after release.
  - resp_valid, resp_last and resp_we = 0; resp_data = 0.
  - Memory re-initialised to the pattern.
  - Beat counter and latency counter = 0.
  - Reset mid-burst or mid-wait aborts the transaction with no further beats.
- Handshakes: a request is accepted on an edge where req_valid && req_ready; a beat transfers on an edge where resp_valid && resp_ready.
- FSM states: IDLE, WAIT, BURST, WACK.
  - IDLE, read accepted: latch base = req_addr with the low log2(BLOCK_WORDS) bits cleared, and offset = those low bits. Go to WAIT with counter = LATENCY. If LATENCY = 0, go directly to BURST.
  - IDLE, write accepted: mem[req_addr] <= req_wdata on the same edge. Go to WACK.
  - WAIT: decrement the counter each cycle; at 0, go to BURST. The first resp_valid is therefore seen exactly LATENCY+1 cycles after the accepting edge.
  - BURST:
    - Beat i (0..BLOCK_WORDS-1) reads address base | ((offset+i) mod BLOCK_WORDS), wrapping within the block.
    - resp_data is a combinational read of the current beat address.
    - resp_last = 1 when i = BLOCK_WORDS-1.
    - resp_valid stays high and data/last stay stable while resp_ready is low.
    - A transfer increments i; the transfer of the last beat returns to IDLE.
  - WACK: resp_valid = 1, resp_we = 1, resp_last = 1, resp_data = written word. Return to IDLE on transfer.
- Throughput: one beat per cycle under continuous resp_ready. req_ready rises the cycle after the final transfer; requests are not pipelined.
- Read-after-write: a read accepted after a write ack returns the new data.
- Out-of-state inputs: req_valid outside IDLE is ignored; resp_ready outside BURST and WACK is ignored.
- Address arithmetic: all arithmetic is modulo its field width; base and offset never carry into each other.

Optional Feature:
MEM_FILL_STATS_EN
- Defined: adds outputs rd_count and wr_count, each 16 bits, reset to 0.
  - rd_count increments on each accepted read request; wr_count on each accepted write.
  - Both saturate at 16'hFFFF.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Decomposition:
- Package mem_fill_pkg: FSM state encoding (IDLE=0, WAIT=1, BURST=2, WACK=3); OFFSET_WIDTH = clog2(BLOCK_WORDS) helper; clog2 function; stats counter width (16).
- Sub-module mem_fill_array: storage with pattern initialisation on reset, one synchronous write port and one combinational read port.
- The FSM, counters and handshake logic stay in mem_fill_responder.

Test Plan:
1. Default parameters, read req_addr=0x013 with resp_ready held at 1:
   - first resp_valid 5 cycles after acceptance;
   - 16 beats, addresses 0x013..0x01F then 0x010..0x012;
   - first data 0x3E0, last data 0x3E1 with resp_last=1;
   - req_ready high the cycle after the last beat.
2. Backpressure during the read of case 1: drop resp_ready for 3 cycles at beat 5 -> beat 5 data held stable and no beat skipped or duplicated; total remains 16 beats.
3. Write 0x055 <- 0x123, then read 0x055:
   - ack beat has resp_we=1, resp_last=1, resp_data=0x123;
   - first read beat = 0x123;
   - second beat (addr 0x056) = 0x3F3^0x056 = 0x3A5.
4. Reset asserted mid-burst after beat 7 -> outputs immediately at reset values; after release, reading 0x055 returns the pattern 0x3A6 (write lost).
5. LATENCY=0, read 0x7FF -> resp_valid one cycle after acceptance; beats 0x7FF, 0x7F0..0x7FE, with no carry out of the block.
6. With MEM_FILL_STATS_EN defined: 3 reads and 2 writes -> rd_count=3, wr_count=2; reset clears both.

Source files
------------

// File: rtl/mem_fill_pkg.sv
// Shared types and helpers for the mem_fill_responder main-memory model.
package mem_fill_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_BURST = 2'd2,
    ST_WACK  = 2'd3
  } state_e;

  localparam int unsigned STATS_WIDTH = 16;
  localparam int unsigned LAT_WIDTH   = 8;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r++;
    return r;
  endfunction

  function automatic int unsigned offset_width(input int unsigned block_words);
    return clog2(block_words);
  endfunction

endpackage

// File: rtl/mem_fill_array.sv
// Word storage: pattern-initialised on reset, one synchronous write port,
// one combinational read port.
module mem_fill_array #(
  parameter int unsigned             ADDR_WIDTH   = 11,
  parameter int unsigned             DATA_WIDTH   = 11,
  parameter logic [DATA_WIDTH-1:0]   FILL_PATTERN = DATA_WIDTH'(11'h3F3)
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic [ADDR_WIDTH-1:0] i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int unsigned a = 0; a < DEPTH; a++) begin
        r_mem[a] <= FILL_PATTERN ^ DATA_WIDTH'(a);
      end
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/mem_fill_responder.sv
// Main-memory model answering block fills (critical word first, wrapped) and
// single-word writes. Optional MEM_FILL_STATS_EN adds rd_count/wr_count.
module mem_fill_responder
  import mem_fill_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH   = 11,
  parameter int unsigned           DATA_WIDTH   = 11,
  parameter int unsigned           BLOCK_WORDS  = 16,
  parameter int unsigned           LATENCY      = 4,
  parameter logic [DATA_WIDTH-1:0] FILL_PATTERN = DATA_WIDTH'(11'h3F3)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic                  req_we,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_data,
  output logic                  resp_last,
  output logic                  resp_we
`ifdef MEM_FILL_STATS_EN
  ,
  output logic [STATS_WIDTH-1:0] rd_count,
  output logic [STATS_WIDTH-1:0] wr_count
`endif
);

  localparam int unsigned OW = offset_width(BLOCK_WORDS);

  state_e                   r_state;
  state_e                   w_next;
  logic [ADDR_WIDTH-OW-1:0] r_base_hi;
  logic [OW-1:0]            r_offset;
  logic [OW-1:0]            r_beat;
  logic [LAT_WIDTH-1:0]     r_lat;
  logic [DATA_WIDTH-1:0]    r_wdata;

  logic                     w_accept;
  logic                     w_xfer;
  logic                     w_last_beat;
  logic                     w_mem_we;
  logic [OW-1:0]            w_wrap;
  logic [ADDR_WIDTH-1:0]    w_rd_addr;
  logic [DATA_WIDTH-1:0]    w_rd_data;

  assign w_accept    = req_valid && req_ready;
  assign w_xfer      = resp_valid && resp_ready;
  assign w_last_beat = (r_beat == '1);
  assign w_mem_we    = w_accept && req_we;
  // Offset arithmetic stays inside the block field; no carry into the base.
  assign w_wrap      = r_offset + r_beat;
  assign w_rd_addr   = {r_base_hi, w_wrap};

  mem_fill_array #(
    .ADDR_WIDTH  (ADDR_WIDTH),
    .DATA_WIDTH  (DATA_WIDTH),
    .FILL_PATTERN(FILL_PATTERN)
  ) u_array (
    .i_clk  (clk),
    .i_rst_n(rst),
    .i_we   (w_mem_we),
    .i_waddr(req_addr),
    .i_wdata(req_wdata),
    .i_raddr(w_rd_addr),
    .o_rdata(w_rd_data)
  );

  always_comb begin
    w_next     = r_state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_last  = 1'b0;
    resp_we    = 1'b0;
    resp_data  = '0;
    case (r_state)
      ST_IDLE: begin
        req_ready = rst;
        if (req_valid && rst) begin
          if (req_we)            w_next = ST_WACK;
          else if (LATENCY == 0) w_next = ST_BURST;
          else                   w_next = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (r_lat <= LAT_WIDTH'(1)) w_next = ST_BURST;
      end
      ST_BURST: begin
        resp_valid = 1'b1;
        resp_data  = w_rd_data;
        resp_last  = w_last_beat;
        if (resp_ready && w_last_beat) w_next = ST_IDLE;
      end
      ST_WACK: begin
        resp_valid = 1'b1;
        resp_we    = 1'b1;
        resp_last  = 1'b1;
        resp_data  = r_wdata;
        if (resp_ready) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= ST_IDLE;
      r_base_hi <= '0;
      r_offset  <= '0;
      r_beat    <= '0;
      r_lat     <= '0;
      r_wdata   <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        ST_IDLE: begin
          if (w_accept && !req_we) begin
            r_base_hi <= req_addr[ADDR_WIDTH-1:OW];
            r_offset  <= req_addr[OW-1:0];
            r_beat    <= '0;
            r_lat     <= LAT_WIDTH'(LATENCY);
          end else if (w_accept) begin
            r_wdata <= req_wdata;
          end
        end
        ST_WAIT: begin
          if (r_lat != '0) r_lat <= r_lat - LAT_WIDTH'(1);
        end
        ST_BURST: begin
          if (w_xfer) r_beat <= r_beat + OW'(1);
        end
        default: ;
      endcase
    end
  end

`ifdef MEM_FILL_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_count <= '0;
      wr_count <= '0;
    end else begin
      if (w_accept && !req_we && rd_count != '1) rd_count <= rd_count + STATS_WIDTH'(1);
      if (w_accept &&  req_we && wr_count != '1) wr_count <= wr_count + STATS_WIDTH'(1);
    end
  end
`else
  // No request statistics in this build.
`endif

endmodule

// File: tb/tb_mem_fill_responder.sv
// Self-checking bench for mem_fill_responder against an array-based memory model.
module tb_mem_fill_responder;

  localparam int LAT_A = 4;
  localparam int LAT_B = 0;
  localparam int BW    = 16;

  logic        clk;
  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [10:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready, resp_last, resp_we;
  logic [10:0] resp_data;

  logic        z_req_valid, z_req_ready, z_req_we;
  logic [10:0] z_req_addr, z_req_wdata;
  logic        z_resp_valid, z_resp_ready, z_resp_last, z_resp_we;
  logic [10:0] z_resp_data;

`ifdef MEM_FILL_STATS_EN
  logic [15:0] rd_count, wr_count, z_rd_count, z_wr_count;
`endif

  int checks = 0;
  int errors = 0;

  logic [10:0] model_mem [2048];
  logic [10:0] g_dq [$];
  bit          g_lq [$];

  mem_fill_responder #(.LATENCY(LAT_A)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_we(req_we), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_last(resp_last), .resp_we(resp_we)
`ifdef MEM_FILL_STATS_EN
    , .rd_count(rd_count), .wr_count(wr_count)
`endif
  );

  mem_fill_responder #(.LATENCY(LAT_B)) dut0 (
    .clk(clk), .rst(rst),
    .req_valid(z_req_valid), .req_ready(z_req_ready), .req_addr(z_req_addr),
    .req_we(z_req_we), .req_wdata(z_req_wdata),
    .resp_valid(z_resp_valid), .resp_ready(z_resp_ready), .resp_data(z_resp_data),
    .resp_last(z_resp_last), .resp_we(z_resp_we)
`ifdef MEM_FILL_STATS_EN
    , .rd_count(z_rd_count), .wr_count(z_wr_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [10:0] pattern(input int a);
    return 11'h3F3 ^ 11'(a);
  endfunction

  function automatic int beat_addr(input int addr, input int i);
    int base;
    base = addr - (addr % BW);
    return base + ((addr % BW + i) % BW);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2048; i++) model_mem[i] = pattern(i);
  endtask

  task automatic read_txn(input logic [10:0] addr, input int stall_at, input int stall_len,
                          input bit rnd_bp, output int lat, output bit timeout,
                          output bit held_ok, output bit ready_after);
    int n, edges, stall_cnt;
    bit have_hold;
    logic [10:0] hold_d;
    logic hold_l;
    timeout = 0; held_ok = 1; lat = -1; ready_after = 0;
    have_hold = 0; stall_cnt = 0; hold_d = '0; hold_l = 0;
    g_dq.delete(); g_lq.delete();
    req_addr = addr; req_we = 0; req_valid = 1; resp_ready = 0;
    n = 0;
    while (!req_ready && n < 100) begin @(posedge clk); #1; n++; end
    if (!req_ready) begin timeout = 1; req_valid = 0; return; end
    @(posedge clk); #1;
    req_valid = 0;
    edges = 0;
    while (g_dq.size() < BW && edges < 400) begin
      if (rnd_bp) resp_ready = 1'($urandom_range(0, 1));
      else if (resp_valid && g_dq.size() == stall_at && stall_cnt < stall_len) resp_ready = 0;
      else resp_ready = 1;
      if (resp_valid && lat < 0) lat = edges + 1;
      if (resp_valid && have_hold && (resp_data !== hold_d || resp_last !== hold_l)) held_ok = 0;
      if (resp_valid && !resp_ready) begin
        hold_d = resp_data; hold_l = resp_last; have_hold = 1;
        if (!rnd_bp && g_dq.size() == stall_at) stall_cnt++;
      end
      if (resp_valid && resp_ready) begin
        have_hold = 0;
        g_dq.push_back(resp_data);
        g_lq.push_back(resp_last);
      end
      @(posedge clk); #1;
      edges++;
    end
    if (g_dq.size() < BW) timeout = 1;
    resp_ready = 0;
    ready_after = req_ready && !resp_valid;
  endtask

  task automatic write_txn(input logic [10:0] addr, input logic [10:0] data, input int delay,
                           output logic [10:0] ack_d, output logic ack_l, output logic ack_w,
                           output bit timeout, output bit held_ok, output bit ready_after);
    int n;
    timeout = 0; held_ok = 1; ready_after = 0;
    ack_d = '0; ack_l = 0; ack_w = 0;
    req_addr = addr; req_we = 1; req_wdata = data; req_valid = 1; resp_ready = 0;
    n = 0;
    while (!req_ready && n < 100) begin @(posedge clk); #1; n++; end
    if (!req_ready) begin timeout = 1; req_valid = 0; req_we = 0; return; end
    @(posedge clk); #1;
    req_valid = 0; req_we = 0;
    n = 0;
    while (!resp_valid && n < 50) begin @(posedge clk); #1; n++; end
    if (!resp_valid) begin timeout = 1; return; end
    ack_d = resp_data; ack_l = resp_last; ack_w = resp_we;
    repeat (delay) begin
      @(posedge clk); #1;
      if (!resp_valid || resp_data !== ack_d) held_ok = 0;
    end
    resp_ready = 1;
    @(posedge clk); #1;
    resp_ready = 0;
    ready_after = req_ready && !resp_valid;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1;
    #1;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (req_ready !== 1'b0 || resp_valid !== 1'b0 || resp_last !== 1'b0 || resp_we !== 1'b0 || resp_data !== 11'h000) begin
      errors++;
      $display("FAIL reset_outputs: ready=%b valid=%b last=%b we=%b data=%h, required 0 0 0 0 000",
               req_ready, resp_valid, resp_last, resp_we, resp_data);
    end
    @(posedge clk); #1;
    rst = 1;
    #1;
    checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: ready=%b valid=%b, required 1 0", req_ready, resp_valid);
    end
  endtask

  task automatic check_burst(input string name, input logic [10:0] addr);
    checks++;
    if (g_dq.size() != BW) begin
      errors++;
      $display("FAIL %s_count: beats=%0d required=%0d", name, g_dq.size(), BW);
    end else begin
      for (int i = 0; i < BW; i++) begin
        checks++;
        if (g_dq[i] !== model_mem[beat_addr(int'(addr), i)] || g_lq[i] !== (i == BW - 1)) begin
          errors++;
          $display("FAIL %s_beat%0d: data=%h last=%b required data=%h last=%b", name, i,
                   g_dq[i], g_lq[i], model_mem[beat_addr(int'(addr), i)], (i == BW - 1));
        end
      end
    end
  endtask

  task automatic test_read_basic();
    int lat; bit to, held, rdy;
    read_txn(11'h013, -1, 0, 0, lat, to, held, rdy);
    checks++;
    if (to || lat != LAT_A + 1) begin
      errors++;
      $display("FAIL read_latency: cycles=%0d timeout=%0b required cycles=%0d", lat, to, LAT_A + 1);
    end
    check_burst("read013", 11'h013);
    checks++;
    if (g_dq.size() == BW && (g_dq[0] !== 11'h3E0 || g_dq[BW-1] !== 11'h3E1)) begin
      errors++;
      $display("FAIL read_endpoints: first=%h last=%h required 3e0 3e1", g_dq[0], g_dq[BW-1]);
    end
    checks++;
    if (!rdy) begin
      errors++;
      $display("FAIL read_ready_after: got 0 required 1");
    end
  endtask

  task automatic test_backpressure();
    int lat; bit to, held, rdy;
    read_txn(11'h013, 5, 3, 0, lat, to, held, rdy);
    checks++;
    if (!held || to) begin
      errors++;
      $display("FAIL bp_hold: held=%0b timeout=%0b required held=1 timeout=0", held, to);
    end
    check_burst("bp013", 11'h013);
  endtask

  task automatic test_write_read();
    logic [10:0] d; logic l, w; bit to, held, rdy; int lat;
    write_txn(11'h055, 11'h123, 0, d, l, w, to, held, rdy);
    model_mem[11'h055] = 11'h123;
    checks++;
    if (to || d !== 11'h123 || l !== 1'b1 || w !== 1'b1 || !rdy) begin
      errors++;
      $display("FAIL write_ack: data=%h last=%b we=%b ready_after=%0b required 123 1 1 1", d, l, w, rdy);
    end
    read_txn(11'h055, -1, 0, 0, lat, to, held, rdy);
    check_burst("raw055", 11'h055);
    checks++;
    if (g_dq.size() == BW && (g_dq[0] !== 11'h123 || g_dq[1] !== 11'h3A5)) begin
      errors++;
      $display("FAIL raw_values: beat0=%h beat1=%h required 123 3a5", g_dq[0], g_dq[1]);
    end
  endtask

  task automatic test_reset_mid_burst();
    int n, cyc, lat; bit to, held, rdy;
    req_addr = 11'h013; req_we = 0; req_valid = 1;
    n = 0;
    while (!req_ready && n < 100) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    req_valid = 0; resp_ready = 1;
    n = 0; cyc = 0;
    while (n < 8 && cyc < 100) begin
      if (resp_valid) n++;
      @(posedge clk); #1;
      cyc++;
    end
    checks++;
    if (n != 8) begin
      errors++;
      $display("FAIL midrst_beats: got %0d required 8", n);
    end
    rst = 0;
    #1;
    checks++;
    if (resp_valid !== 1'b0 || resp_last !== 1'b0 || resp_we !== 1'b0 || resp_data !== 11'h000 || req_ready !== 1'b0) begin
      errors++;
      $display("FAIL midrst_outputs: valid=%b last=%b we=%b data=%h ready=%b required 0 0 0 000 0",
               resp_valid, resp_last, resp_we, resp_data, req_ready);
    end
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1;
    @(posedge clk); #1;
    checks++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL midrst_idle: valid=%b ready=%b required 0 1", resp_valid, req_ready);
    end
    resp_ready = 0;
    read_txn(11'h055, -1, 0, 0, lat, to, held, rdy);
    check_burst("postrst055", 11'h055);
    checks++;
    if (g_dq.size() == BW && g_dq[0] !== 11'h3A6) begin
      errors++;
      $display("FAIL postrst_pattern: beat0=%h required 3a6", g_dq[0]);
    end
  endtask

  task automatic test_latency0();
    int n, edges, lat;
    logic [10:0] dq [$];
    bit lq [$];
    z_req_addr = 11'h7FF; z_req_we = 0; z_req_valid = 1; z_resp_ready = 1;
    n = 0;
    while (!z_req_ready && n < 100) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    z_req_valid = 0;
    edges = 0; lat = -1;
    while (dq.size() < BW && edges < 100) begin
      if (z_resp_valid && lat < 0) lat = edges + 1;
      if (z_resp_valid) begin dq.push_back(z_resp_data); lq.push_back(z_resp_last); end
      @(posedge clk); #1;
      edges++;
    end
    z_resp_ready = 0;
    checks++;
    if (lat != LAT_B + 1) begin
      errors++;
      $display("FAIL lat0_latency: cycles=%0d required %0d", lat, LAT_B + 1);
    end
    checks++;
    if (dq.size() != BW) begin
      errors++;
      $display("FAIL lat0_count: beats=%0d required %0d", dq.size(), BW);
    end else begin
      for (int i = 0; i < BW; i++) begin
        int a;
        a = (i == 0) ? 'h7FF : 'h7F0 + i - 1;
        checks++;
        if (dq[i] !== pattern(a) || lq[i] !== (i == BW - 1)) begin
          errors++;
          $display("FAIL lat0_beat%0d: data=%h last=%b required data=%h last=%b",
                   i, dq[i], lq[i], pattern(a), (i == BW - 1));
        end
      end
    end
  endtask

  task automatic test_random();
    logic [10:0] addr, d, ad; logic l, w; bit to, held, rdy; int lat, dly;
    for (int t = 0; t < 24; t++) begin
      addr = 11'($urandom_range(0, 2047));
      if ($urandom_range(0, 2) == 0) begin
        d = 11'($urandom_range(0, 2047));
        dly = $urandom_range(0, 3);
        write_txn(addr, d, dly, ad, l, w, to, held, rdy);
        model_mem[addr] = d;
        checks++;
        if (to || !held || ad !== d || l !== 1'b1 || w !== 1'b1 || !rdy) begin
          errors++;
          $display("FAIL rnd_write%0d: data=%h last=%b we=%b held=%0b ready=%0b required %h 1 1 1 1",
                   t, ad, l, w, held, rdy, d);
        end
      end else begin
        read_txn(addr, -1, 0, 1, lat, to, held, rdy);
        checks++;
        if (to || !held || !rdy || lat != LAT_A + 1) begin
          errors++;
          $display("FAIL rnd_read%0d: timeout=%0b held=%0b ready=%0b latency=%0d required 0 1 1 %0d",
                   t, to, held, rdy, lat, LAT_A + 1);
        end
        check_burst("rnd", addr);
      end
    end
  endtask

`ifdef MEM_FILL_STATS_EN
  task automatic test_stats();
    logic [10:0] ad; logic l, w; bit to, held, rdy; int lat;
    do_reset();
    for (int i = 0; i < 3; i++) read_txn(11'($urandom_range(0, 2047)), -1, 0, 0, lat, to, held, rdy);
    for (int i = 0; i < 2; i++) begin
      write_txn(11'h100 + 11'(i), 11'h0AA, 0, ad, l, w, to, held, rdy);
      model_mem[11'h100 + i] = 11'h0AA;
    end
    checks++;
    if (rd_count !== 16'd3 || wr_count !== 16'd2) begin
      errors++;
      $display("FAIL stats_count: rd=%0d wr=%0d required 3 2", rd_count, wr_count);
    end
    do_reset();
    checks++;
    if (rd_count !== 16'd0 || wr_count !== 16'd0) begin
      errors++;
      $display("FAIL stats_reset: rd=%0d wr=%0d required 0 0", rd_count, wr_count);
    end
  endtask
`endif

  initial begin
    rst = 0;
    req_valid = 0; req_we = 0; req_addr = '0; req_wdata = '0; resp_ready = 0;
    z_req_valid = 0; z_req_we = 0; z_req_addr = '0; z_req_wdata = '0; z_resp_ready = 0;
    model_reset();
    repeat (2) @(posedge clk);
    test_reset();
    test_read_basic();
    test_backpressure();
    test_write_read();
    test_reset_mid_burst();
    test_latency0();
    test_random();
`ifdef MEM_FILL_STATS_EN
    test_stats();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
